seven_seg_scan: RTL and testbench

- Display-side reader of the stopwatch digit bus. It takes the four BCD digits d0..d3 (seconds ones/tens, minutes ones/tens) written by the counter logic.
- It time-multiplexes them onto one shared 7-segment bus with per-digit anode select, adding ghost-suppression guard time and a coherent per-frame digit snapshot.
- In adjust mode it blinks the selected field.
- It sits between the minute/second counter and the board's 4-digit common-anode display.

---
 rtl/seven_seg_scan.sv | 123 ++++++++++++
 tb/tb_seven_seg_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit multiplexed 7-segment scanner with frame snapshot and field blink
// Digits are latched once per frame and strobed onto a shared active-low bus with a per-slot guard gap.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       ADJ,
  input  logic       SEL,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [6:0] dispDigit,
  output logic [3:0] selector,
  output logic       frame_tick
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GUARD_END  = RW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  logic [RW-1:0] ref_cnt;
  logic [1:0]    slot;
  logic [3:0]    snap [4];
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          ref_last;
  logic          frame_end;
  logic          in_field;
  logic          blank;
  logic [3:0]    sel_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] encode(input logic [3:0] v);
    case (v)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = 7'b0111111;
    endcase
  endfunction

  assign ref_last  = (ref_cnt == REF_LAST);
  assign frame_end = ref_last && (slot == 2'd3);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      ref_cnt    <= '0;
      slot       <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      ref_cnt    <= ref_last ? '0 : ref_cnt + 1'b1;
      frame_tick <= frame_end;
      if (ref_last) slot <= slot + 2'd1;
    end
  end

  // Snapshot is taken on the last cycle of slot 3 so a whole frame shows one coherent time.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      snap[0] <= 4'd0;
      snap[1] <= 4'd0;
      snap[2] <= 4'd0;
      snap[3] <= 4'd0;
    end else if (frame_end) begin
      snap[0] <= d0;
      snap[1] <= d1;
      snap[2] <= d2;
      snap[3] <= d3;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!ADJ) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // ADJ/SEL are used live so a mode or field change shows on the very next update.
  always_comb begin
    in_field = SEL ? ~slot[1] : slot[1];
    blank    = ADJ && !blink_on && in_field;
    sel_next = 4'b1111;
    seg_next = SEG_OFF;
    if (ref_cnt >= GUARD_END) begin
      sel_next = ~(4'b0001 << slot);
      if (!blank) seg_next = encode(snap[slot]);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      selector  <= 4'b1111;
      dispDigit <= SEG_OFF;
    end else begin
      selector  <= sel_next;
      dispDigit <= seg_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench for seven_seg_scan
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_seven_seg_scan;

  localparam int RD = 8;
  localparam int GD = 1;
  localparam int BD = 20;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       ADJ;
  logic       SEL;
  logic [3:0] d0, d1, d2, d3;
  logic [6:0] dispDigit;
  logic [3:0] selector;
  logic       frame_tick;

  seven_seg_scan #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_DIV(BD)) dut (
    .clk(clk), .RESET_N(RESET_N), .ADJ(ADJ), .SEL(SEL),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .dispDigit(dispDigit), .selector(selector), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         phase = 0;
  int         p = 0;
  int         adj_n = 0;
  logic [3:0] m_snap [4];

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic check(input int ph, input logic [3:0] es, input logic [6:0] eg, input logic et);
    n_cmp++;
    if (selector !== es || dispDigit !== eg || frame_tick !== et) begin
      n_bad++;
      $display("FAIL scan ph=%0d t=%0t: got sel=%b seg=%b tick=%b, want sel=%b seg=%b tick=%b",
               ph, $time, selector, dispDigit, frame_tick, es, eg, et);
    end
  endtask

  // Expected outputs for the coming edge, from position in the scan and the bench-held snapshot.
  task automatic cycle();
    exp_t e;
    int   slot, c;
    logic blanked, field;
    e.ph = phase;
    e.sel = 4'b1111;
    e.seg = 7'b1111111;
    e.tick = 1'b0;
    if (!RESET_N) begin
      p = 0;
      adj_n = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    end else begin
      slot = (p / RD) % 4;
      c = p % RD;
      if (c >= GD) begin
        e.sel = ~(4'b0001 << slot);
        field = SEL ? (slot < 2) : (slot >= 2);
        blanked = ADJ && (((adj_n / BD) % 2) == 1) && field;
        e.seg = blanked ? 7'b1111111 : seg_of(m_snap[slot]);
      end
      e.tick = ((p % (4 * RD)) == 4 * RD - 1);
      if (e.tick) begin
        m_snap[0] = d0; m_snap[1] = d1; m_snap[2] = d2; m_snap[3] = d3;
      end
      p++;
      adj_n = ADJ ? adj_n + 1 : 0;
    end
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.ph, e.sel, e.seg, e.tick);
      end
    end
  end

  initial begin : stim
    RESET_N = 1'b0;
    ADJ = 1'b0; SEL = 1'b0;
    d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
    phase = 0;
    run(3);
    check(0, 4'b1111, 7'b1111111, 1'b0);
    RESET_N = 1'b1;

    phase = 1;
    run(12);
    d0 = 4'd7; d1 = 4'd3; d2 = 4'd9; d3 = 4'd5;
    run(52);

    phase = 2;
    d1 = 4'hC;
    run(64);

    phase = 3;
    ADJ = 1'b1; SEL = 1'b1;
    run(30);
    phase = 4;
    SEL = 1'b0;
    run(35);
    phase = 5;
    ADJ = 1'b0;
    run(10);
    phase = 6;
    ADJ = 1'b1;
    run(30);
    ADJ = 1'b0;

    phase = 7;
    while (((p / RD) % 4) != 2 || (p % RD) != 4) cycle();
    #4;
    RESET_N = 1'b0;
    #1;
    check(7, 4'b1111, 7'b1111111, 1'b0);
    phase = 8;
    run(3);
    RESET_N = 1'b1;
    phase = 9;
    run(40);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
